spandex_home_rsp: RTL and testbench

- Home-side responder for the Spandex L2 request channel. It accepts the L2's outgoing requests (ReqV, ReqS, ReqO, ReqOdata, ReqWT, ReqWB) and performs the backing-memory read or masked write each one needs.
- It returns the matching response on the L2 rsp_in channel.
- It sits between the L2 req_out/rsp_in ports and a simple line-wide memory port. It serves single-L2 integration and is the reference home model for L2 verification.

---
 rtl/spandex_home_rsp_pkg.sv | 41 ++++
 rtl/spandex_home_rsp_map.sv | 32 +++
 rtl/spandex_home_rsp.sv | 162 ++++++++++++++++
 tb/tb_spandex_home_rsp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spandex_home_rsp_pkg.sv
// Shared opcode encodings, widths, FSM state type and request-buffer layout
// for the Spandex home-side responder.
package spandex_home_rsp_pkg;

   localparam int LINE_ADDR_BITS     = 28;
   localparam int WORDS_PER_LINE     = 4;
   localparam int BITS_PER_WORD      = 32;
   localparam int MIX_MSG_TYPE_WIDTH = 5;
   localparam int NOC_ID_W           = 4;

   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] REQ_V     = 5'h00;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] REQ_S     = 5'h01;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] REQ_O     = 5'h02;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] REQ_ODATA = 5'h03;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] REQ_WT    = 5'h04;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] REQ_WB    = 5'h05;

   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] RSP_V     = 5'h10;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] RSP_S     = 5'h11;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] RSP_O     = 5'h12;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] RSP_ODATA = 5'h13;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] RSP_WT    = 5'h14;
   localparam logic [MIX_MSG_TYPE_WIDTH-1:0] RSP_WB    = 5'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WR_REQ,
      ST_RSP
   } home_state_t;

   typedef struct packed {
      logic [MIX_MSG_TYPE_WIDTH-1:0]            opcode;
      logic [LINE_ADDR_BITS-1:0]                addr;
      logic                                     hprot;
      logic [WORDS_PER_LINE*BITS_PER_WORD-1:0]  line;
      logic [WORDS_PER_LINE-1:0]                mask;
   } home_req_buf_t;

endpackage

// File: rtl/spandex_home_rsp_map.sv
// Combinational decode of a request opcode into its response opcode and the
// memory work it needs.
module spandex_home_rsp_map
   import spandex_home_rsp_pkg::*;
(
   input  logic [MIX_MSG_TYPE_WIDTH-1:0] i_req_msg,
   output logic [MIX_MSG_TYPE_WIDTH-1:0] o_rsp_msg,
   output logic                          o_has_data,
   output logic                          o_needs_read,
   output logic                          o_needs_write,
   output logic                          o_known
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      o_rsp_msg     = '0;
      o_has_data    = 1'b0;
      o_needs_read  = 1'b0;
      o_needs_write = 1'b0;
      o_known       = 1'b1;
      case (i_req_msg)
         REQ_V:     begin o_rsp_msg = RSP_V;     o_has_data = 1'b1; o_needs_read = 1'b1; end
         REQ_S:     begin o_rsp_msg = RSP_S;     o_has_data = 1'b1; o_needs_read = 1'b1; end
         REQ_ODATA: begin o_rsp_msg = RSP_ODATA; o_has_data = 1'b1; o_needs_read = 1'b1; end
         REQ_O:     o_rsp_msg = RSP_O;
         REQ_WT:    begin o_rsp_msg = RSP_WT; o_needs_write = 1'b1; end
         REQ_WB:    begin o_rsp_msg = RSP_WB; o_needs_write = 1'b1; end
         default:   o_known = 1'b0;
      endcase
   end

endmodule

// File: rtl/spandex_home_rsp.sv
// Home-side responder: serves one L2 request at a time against a line-wide
// memory port and returns the matching response on the L2 rsp_in channel.
module spandex_home_rsp
   import spandex_home_rsp_pkg::*;
#(
   parameter int LINE_ADDR_W = LINE_ADDR_BITS,
   parameter int WORDS       = WORDS_PER_LINE,
   parameter int WORD_W      = BITS_PER_WORD,
   parameter int HOME_ID     = 0,
   parameter int CNT_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,

   input  logic                          req_in_valid,
   output logic                          req_in_ready,
   input  logic [MIX_MSG_TYPE_WIDTH-1:0] req_in_coh_msg,
   input  logic                          req_in_hprot,
   input  logic [LINE_ADDR_W-1:0]        req_in_addr,
   input  logic [WORDS*WORD_W-1:0]       req_in_line,
   input  logic [WORDS-1:0]              req_in_word_mask,

   output logic                          mem_rd_valid,
   input  logic                          mem_rd_ready,
   output logic [LINE_ADDR_W-1:0]        mem_rd_addr,
   input  logic                          mem_rd_data_valid,
   output logic                          mem_rd_data_ready,
   input  logic [WORDS*WORD_W-1:0]       mem_rd_data,

   output logic                          mem_wr_valid,
   input  logic                          mem_wr_ready,
   output logic [LINE_ADDR_W-1:0]        mem_wr_addr,
   output logic [WORDS*WORD_W-1:0]       mem_wr_line,
   output logic [WORDS-1:0]              mem_wr_mask,
   output logic                          mem_hprot,

   output logic                          rsp_out_valid,
   input  logic                          rsp_out_ready,
   output logic [MIX_MSG_TYPE_WIDTH-1:0] rsp_out_coh_msg,
   output logic [NOC_ID_W-1:0]           rsp_out_req_id,
   output logic [LINE_ADDR_W-1:0]        rsp_out_addr,
   output logic [WORDS*WORD_W-1:0]       rsp_out_line,
   output logic [WORDS-1:0]              rsp_out_word_mask,

   output logic                          err_unknown,
   output logic [CNT_W-1:0]              served_cnt
);

   home_state_t                   r_state;
   home_state_t                   w_next;
   home_req_buf_t                 r_buf;
   logic [MIX_MSG_TYPE_WIDTH-1:0] r_rsp_msg;
   logic                          r_has_data;
   logic [WORDS*WORD_W-1:0]       r_rd_line;
   logic                          r_err_unknown;
   logic [CNT_W-1:0]              r_served_cnt;

   logic [MIX_MSG_TYPE_WIDTH-1:0] w_rsp_msg;
   logic                          w_has_data;
   logic                          w_needs_read;
   logic                          w_needs_write;
   logic                          w_known;
   logic                          w_accept;

   spandex_home_rsp_map u_map (
      .i_req_msg     (req_in_coh_msg),
      .o_rsp_msg     (w_rsp_msg),
      .o_has_data    (w_has_data),
      .o_needs_read  (w_needs_read),
      .o_needs_write (w_needs_write),
      .o_known       (w_known)
   );

   assign w_accept = req_in_valid && (r_state == ST_IDLE);

   always_comb begin
      w_next            = r_state;
      req_in_ready      = 1'b0;
      mem_rd_valid      = 1'b0;
      mem_rd_data_ready = 1'b0;
      mem_wr_valid      = 1'b0;
      rsp_out_valid     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_in_ready = 1'b1;
            if (req_in_valid && w_known) begin
               if (w_needs_read)
                  w_next = ST_RD_REQ;
               else if (w_needs_write && (req_in_word_mask != '0))
                  w_next = ST_WR_REQ;
               else
                  w_next = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            mem_rd_valid = 1'b1;
            if (mem_rd_ready) w_next = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            mem_rd_data_ready = 1'b1;
            if (mem_rd_data_valid) w_next = ST_RSP;
         end
         ST_WR_REQ: begin
            mem_wr_valid = 1'b1;
            if (mem_wr_ready) w_next = ST_RSP;
         end
         ST_RSP: begin
            rsp_out_valid = 1'b1;
            if (rsp_out_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state       <= ST_IDLE;
         // NOTE: the data registers are reset too, so a reset mid-request leaves no stale line or opcode behind.
         r_buf         <= '0;
         r_rsp_msg     <= '0;
         r_has_data    <= 1'b0;
         r_rd_line     <= '0;
         r_err_unknown <= 1'b0;
         r_served_cnt  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept && w_known) begin
            r_buf.opcode <= req_in_coh_msg;
            r_buf.addr   <= req_in_addr;
            r_buf.hprot  <= req_in_hprot;
            r_buf.line   <= req_in_line;
            r_buf.mask   <= req_in_word_mask;
            r_rsp_msg    <= w_rsp_msg;
            r_has_data   <= w_has_data;
         end
         // Unknown opcodes are consumed and dropped; only the sticky flag records them.
         if (w_accept && !w_known)
            r_err_unknown <= 1'b1;
         if ((r_state == ST_RD_WAIT) && mem_rd_data_valid)
            r_rd_line <= mem_rd_data;
         if ((r_state == ST_RSP) && rsp_out_ready)
            r_served_cnt <= r_served_cnt + 1'b1;
      end
   end

   assign mem_rd_addr       = r_buf.addr;
   assign mem_wr_addr       = r_buf.addr;
   assign mem_wr_line       = r_buf.line;
   assign mem_wr_mask       = r_buf.mask;
   assign mem_hprot         = r_buf.hprot;

   assign rsp_out_coh_msg   = r_rsp_msg;
   assign rsp_out_req_id    = NOC_ID_W'(HOME_ID);
   assign rsp_out_addr      = r_buf.addr;
   assign rsp_out_line      = r_has_data ? r_rd_line : '0;
   assign rsp_out_word_mask = r_buf.mask;

   assign err_unknown       = r_err_unknown;
   assign served_cnt        = r_served_cnt;

endmodule

// File: tb/tb_spandex_home_rsp.sv
// Directed bench for spandex_home_rsp: inputs driven and outputs checked on the
// falling edge, expected values written out by hand for each step.
module tb_spandex_home_rsp;
   import spandex_home_rsp_pkg::*;

   localparam int AW = LINE_ADDR_BITS;
   localparam int LW = WORDS_PER_LINE * BITS_PER_WORD;
   localparam int MW = WORDS_PER_LINE;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          req_in_valid;
   logic                          req_in_ready;
   logic [MIX_MSG_TYPE_WIDTH-1:0] req_in_coh_msg;
   logic                          req_in_hprot;
   logic [AW-1:0]                 req_in_addr;
   logic [LW-1:0]                 req_in_line;
   logic [MW-1:0]                 req_in_word_mask;
   logic                          mem_rd_valid;
   logic                          mem_rd_ready;
   logic [AW-1:0]                 mem_rd_addr;
   logic                          mem_rd_data_valid;
   logic                          mem_rd_data_ready;
   logic [LW-1:0]                 mem_rd_data;
   logic                          mem_wr_valid;
   logic                          mem_wr_ready;
   logic [AW-1:0]                 mem_wr_addr;
   logic [LW-1:0]                 mem_wr_line;
   logic [MW-1:0]                 mem_wr_mask;
   logic                          mem_hprot;
   logic                          rsp_out_valid;
   logic                          rsp_out_ready;
   logic [MIX_MSG_TYPE_WIDTH-1:0] rsp_out_coh_msg;
   logic [NOC_ID_W-1:0]           rsp_out_req_id;
   logic [AW-1:0]                 rsp_out_addr;
   logic [LW-1:0]                 rsp_out_line;
   logic [MW-1:0]                 rsp_out_word_mask;
   logic                          err_unknown;
   logic [15:0]                   served_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int rd_cycles = 0;
   int wr_cycles = 0;

   spandex_home_rsp #(.HOME_ID(0), .CNT_W(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_in_valid      (req_in_valid),
      .req_in_ready      (req_in_ready),
      .req_in_coh_msg    (req_in_coh_msg),
      .req_in_hprot      (req_in_hprot),
      .req_in_addr       (req_in_addr),
      .req_in_line       (req_in_line),
      .req_in_word_mask  (req_in_word_mask),
      .mem_rd_valid      (mem_rd_valid),
      .mem_rd_ready      (mem_rd_ready),
      .mem_rd_addr       (mem_rd_addr),
      .mem_rd_data_valid (mem_rd_data_valid),
      .mem_rd_data_ready (mem_rd_data_ready),
      .mem_rd_data       (mem_rd_data),
      .mem_wr_valid      (mem_wr_valid),
      .mem_wr_ready      (mem_wr_ready),
      .mem_wr_addr       (mem_wr_addr),
      .mem_wr_line       (mem_wr_line),
      .mem_wr_mask       (mem_wr_mask),
      .mem_hprot         (mem_hprot),
      .rsp_out_valid     (rsp_out_valid),
      .rsp_out_ready     (rsp_out_ready),
      .rsp_out_coh_msg   (rsp_out_coh_msg),
      .rsp_out_req_id    (rsp_out_req_id),
      .rsp_out_addr      (rsp_out_addr),
      .rsp_out_line      (rsp_out_line),
      .rsp_out_word_mask (rsp_out_word_mask),
      .err_unknown       (err_unknown),
      .served_cnt        (served_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_valid) rd_cycles <= rd_cycles + 1;
      if (mem_wr_valid) wr_cycles <= wr_cycles + 1;
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic [MIX_MSG_TYPE_WIDTH-1:0] op, input logic [AW-1:0] addr,
                            input logic hprot, input logic [LW-1:0] line, input logic [MW-1:0] mask);
      req_in_valid     = 1'b1;
      req_in_coh_msg   = op;
      req_in_addr      = addr;
      req_in_hprot     = hprot;
      req_in_line      = line;
      req_in_word_mask = mask;
   endtask

   logic [LW-1:0] line_a5;
   logic [LW-1:0] line_1234;
   logic [LW-1:0] line_s;
   int rd_base;
   int wr_base;

   initial begin
      line_a5   = {4{32'hA5A5_A5A5}};
      line_1234 = {32'd4, 32'd3, 32'd2, 32'd1};
      line_s    = {32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'hCAFE_F00D};

      rst = 1'b1;
      req_in_valid = 1'b0; req_in_coh_msg = '0; req_in_hprot = 1'b0;
      req_in_addr = '0; req_in_line = '0; req_in_word_mask = '0;
      mem_rd_ready = 1'b0; mem_rd_data_valid = 1'b0; mem_rd_data = '0;
      mem_wr_ready = 1'b0; rsp_out_ready = 1'b0;
      tick(); tick();
      check("rst_rd_valid", mem_rd_valid, 1'b0);
      check("rst_wr_valid", mem_wr_valid, 1'b0);
      check("rst_rsp_valid", rsp_out_valid, 1'b0);
      check("rst_err", err_unknown, 1'b0);
      check("rst_cnt", served_cnt, 16'd0);
      rst = 1'b0;
      tick();
      check("idle_ready", req_in_ready, 1'b1);

      // ReqV, rd_ready delayed 3 cycles
      drive_req(REQ_V, 28'h1234, 1'b0, '0, 4'b1111);
      tick();
      req_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("v_rd_valid_hold", mem_rd_valid, 1'b1);
         check("v_rd_addr", mem_rd_addr, 28'h1234);
         check("v_busy_ready", req_in_ready, 1'b0);
         tick();
      end
      mem_rd_ready = 1'b1;
      tick();
      mem_rd_ready = 1'b0;
      check("v_rd_valid_drop", mem_rd_valid, 1'b0);
      check("v_data_ready", mem_rd_data_ready, 1'b1);
      mem_rd_data_valid = 1'b1; mem_rd_data = line_a5;
      tick();
      mem_rd_data_valid = 1'b0; mem_rd_data = '0;
      check("v_rsp_valid", rsp_out_valid, 1'b1);
      check("v_rsp_msg", rsp_out_coh_msg, RSP_V);
      check("v_rsp_addr", rsp_out_addr, 28'h1234);
      check("v_rsp_line", rsp_out_line, line_a5);
      check("v_rsp_id", rsp_out_req_id, 4'd0);
      check("v_cnt_before", served_cnt, 16'd0);
      rsp_out_ready = 1'b1;
      tick();
      rsp_out_ready = 1'b0;
      check("v_cnt", served_cnt, 16'd1);
      check("v_rsp_drop", rsp_out_valid, 1'b0);
      check("v_ready_again", req_in_ready, 1'b1);

      // ReqWT masked write
      drive_req(REQ_WT, 28'h40, 1'b1, line_1234, 4'b0101);
      tick();
      req_in_valid = 1'b0;
      check("wt_wr_valid", mem_wr_valid, 1'b1);
      check("wt_wr_addr", mem_wr_addr, 28'h40);
      check("wt_wr_line", mem_wr_line, line_1234);
      check("wt_wr_mask", mem_wr_mask, 4'b0101);
      check("wt_hprot", mem_hprot, 1'b1);
      check("wt_no_rd", mem_rd_valid, 1'b0);
      tick();
      check("wt_wr_hold", mem_wr_valid, 1'b1);
      mem_wr_ready = 1'b1;
      tick();
      mem_wr_ready = 1'b0;
      check("wt_wr_drop", mem_wr_valid, 1'b0);
      check("wt_rsp_valid", rsp_out_valid, 1'b1);
      check("wt_rsp_msg", rsp_out_coh_msg, RSP_WT);
      check("wt_rsp_line", rsp_out_line, {LW{1'b0}});
      check("wt_rsp_mask", rsp_out_word_mask, 4'b0101);
      rsp_out_ready = 1'b1;
      tick();
      rsp_out_ready = 1'b0;
      check("wt_cnt", served_cnt, 16'd2);

      // ReqWB, zero mask: memory skipped
      wr_base = wr_cycles;
      drive_req(REQ_WB, 28'h80, 1'b0, line_1234, 4'b0000);
      tick();
      req_in_valid = 1'b0;
      check("wb_rsp_valid", rsp_out_valid, 1'b1);
      check("wb_rsp_msg", rsp_out_coh_msg, RSP_WB);
      check("wb_rsp_line", rsp_out_line, {LW{1'b0}});
      check("wb_wr_valid", mem_wr_valid, 1'b0);
      rsp_out_ready = 1'b1;
      tick();
      rsp_out_ready = 1'b0;
      check("wb_no_wr", wr_cycles - wr_base, 0);
      check("wb_cnt", served_cnt, 16'd3);

      // ReqO with back-pressure
      rd_base = rd_cycles;
      wr_base = wr_cycles;
      drive_req(REQ_O, 28'h7, 1'b0, line_a5, 4'b0011);
      tick();
      drive_req(REQ_S, 28'h99, 1'b0, '0, 4'b1111);
      for (int i = 0; i < 5; i++) begin
         check("o_rsp_valid", rsp_out_valid, 1'b1);
         check("o_rsp_msg", rsp_out_coh_msg, RSP_O);
         check("o_rsp_addr", rsp_out_addr, 28'h7);
         check("o_rsp_line", rsp_out_line, {LW{1'b0}});
         check("o_rsp_mask", rsp_out_word_mask, 4'b0011);
         check("o_req_ready", req_in_ready, 1'b0);
         tick();
      end
      req_in_valid = 1'b0;
      rsp_out_ready = 1'b1;
      tick();
      rsp_out_ready = 1'b0;
      check("o_no_rd", rd_cycles - rd_base, 0);
      check("o_no_wr", wr_cycles - wr_base, 0);
      check("o_cnt", served_cnt, 16'd4);

      // Unknown opcode, then ReqS
      drive_req(5'h1F, 28'h3, 1'b0, '0, 4'b1111);
      tick();
      req_in_valid = 1'b0;
      check("unk_err", err_unknown, 1'b1);
      check("unk_idle", req_in_ready, 1'b1);
      check("unk_no_rsp", rsp_out_valid, 1'b0);
      tick();
      check("unk_err_sticky", err_unknown, 1'b1);
      check("unk_no_rsp2", rsp_out_valid, 1'b0);
      drive_req(REQ_S, 28'h55, 1'b0, '0, 4'b1111);
      mem_rd_ready = 1'b1;
      tick();
      req_in_valid = 1'b0;
      check("s_rd_valid", mem_rd_valid, 1'b1);
      check("s_rd_addr", mem_rd_addr, 28'h55);
      tick();
      mem_rd_ready = 1'b0;
      mem_rd_data_valid = 1'b1; mem_rd_data = line_s;
      tick();
      mem_rd_data_valid = 1'b0; mem_rd_data = '0;
      check("s_rsp_valid", rsp_out_valid, 1'b1);
      check("s_rsp_msg", rsp_out_coh_msg, RSP_S);
      check("s_rsp_line", rsp_out_line, line_s);
      rsp_out_ready = 1'b1;
      tick();
      rsp_out_ready = 1'b0;
      check("s_cnt", served_cnt, 16'd5);
      check("s_err_still", err_unknown, 1'b1);

      // Reset while waiting for read data
      drive_req(REQ_V, 28'h99, 1'b0, '0, 4'b1111);
      mem_rd_ready = 1'b1;
      tick();
      req_in_valid = 1'b0;
      tick();
      mem_rd_ready = 1'b0;
      check("r_in_wait", mem_rd_data_ready, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("r_rd_valid", mem_rd_valid, 1'b0);
      check("r_data_ready", mem_rd_data_ready, 1'b0);
      check("r_wr_valid", mem_wr_valid, 1'b0);
      check("r_rsp_valid", rsp_out_valid, 1'b0);
      check("r_cnt", served_cnt, 16'd0);
      check("r_err", err_unknown, 1'b0);
      mem_rd_data_valid = 1'b1; mem_rd_data = line_a5;
      rsp_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("r_late_no_rsp", rsp_out_valid, 1'b0);
         check("r_late_idle", req_in_ready, 1'b1);
      end
      mem_rd_data_valid = 1'b0;
      rsp_out_ready = 1'b0;
      check("r_cnt_final", served_cnt, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
